// File: rtl/param_rf_pkg.sv
// param_rf_pkg
//   Shared definitions for the parameterised register file.
//   rf_fun_e : FunSel operation encoding used by param_reg_file and rf_cell.
package param_rf_pkg;

  typedef enum logic [1:0] {
    RF_CLR  = 2'b00,
    RF_LOAD = 2'b01,
    RF_DEC  = 2'b10,
    RF_INC  = 2'b11
  } rf_fun_e;

endpackage : param_rf_pkg

// File: rtl/rf_cell.sv
// rf_cell
//   One register of the register file plus its update and wrap/clamp logic.
//   Build option: define PARAM_RF_SAT_EN for saturating increment/decrement
//   (clamp at all-ones / zero); otherwise arithmetic wraps modulo 2^WIDTH.
// Ports
//   Clock  in  : rising-edge clock
//   Reset  in  : synchronous active-high reset, clears the register
//   En     in  : register enable (its RSel bit)
//   FunSel in  : operation, see rf_fun_e
//   HalfLd in  : load only one half-word (load only)
//   LH     in  : half select for HalfLd, 0 low / 1 high
//   I      in  : write data
//   Q      out : stored value
//   Wrap   out : combinational, this edge's inc/dec wraps (or clamps)
module rf_cell
  import param_rf_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             En,
  input  logic [1:0]       FunSel,
  input  logic             HalfLd,
  input  logic             LH,
  input  logic [WIDTH-1:0] I,
  output logic [WIDTH-1:0] Q,
  output logic             Wrap
);

  localparam int HALF = WIDTH / 2;
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  rf_fun_e          fun;

  assign fun = rf_fun_e'(FunSel);

  always_comb begin
    q_d  = q_q;
    Wrap = 1'b0;
    if (En) begin
      unique case (fun)
        RF_CLR:  q_d = '0;
        RF_LOAD: begin
          if (!HalfLd)
            q_d = I;
          else if (LH)
            q_d = {I[HALF-1:0], q_q[HALF-1:0]};
          else
            q_d = {q_q[WIDTH-1:HALF], I[HALF-1:0]};
        end
        RF_DEC: begin
          // Same boundary condition flags a wrap or a clamp.
          Wrap = (q_q == '0);
`ifdef PARAM_RF_SAT_EN
          q_d = Wrap ? q_q : (q_q - ONE);
`else
          q_d = q_q - ONE;
`endif
        end
        RF_INC: begin
          Wrap = (q_q == ALL_ONES);
`ifdef PARAM_RF_SAT_EN
          q_d = Wrap ? q_q : (q_q + ONE);
`else
          q_d = q_q + ONE;
`endif
        end
        default: q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) q_q <= '0;
    else       q_q <= q_d;
  end

  assign Q = q_q;

endmodule : rf_cell

// File: rtl/param_reg_file.sv
// param_reg_file
//   DEPTH x WIDTH register file with a shared write/operation bus, a
//   per-register enable mask and two combinational read ports.
//   Build option: PARAM_RF_SAT_EN selects saturating inc/dec (see rf_cell).
// Ports
//   Clock  in  : rising-edge clock
//   Reset  in  : synchronous active-high reset (registers and Ovf)
//   I      in  : write data
//   O1Sel  in  : read port 1 index
//   O2Sel  in  : read port 2 index
//   FunSel in  : 00 clear, 01 load, 10 decrement, 11 increment
//   RSel   in  : enable mask, bit k = register k
//   HalfLd in  : load only one half-word
//   LH     in  : half select when HalfLd=1
//   O1     out : register O1Sel (0 when index >= DEPTH)
//   O2     out : register O2Sel (0 when index >= DEPTH)
//   Ovf    out : registered, any enabled register wrapped/clamped last edge
module param_reg_file
  import param_rf_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int SELW  = $clog2(DEPTH)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] I,
  input  logic [SELW-1:0]  O1Sel,
  input  logic [SELW-1:0]  O2Sel,
  input  logic [1:0]       FunSel,
  input  logic [DEPTH-1:0] RSel,
  input  logic             HalfLd,
  input  logic             LH,
  output logic [WIDTH-1:0] O1,
  output logic [WIDTH-1:0] O2,
  output logic             Ovf
);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] wrap;
  logic             ovf_q;
  logic             ovf_d;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cell
      rf_cell #(
        .WIDTH (WIDTH)
      ) u_cell (
        .Clock  (Clock),
        .Reset  (Reset),
        .En     (RSel[gi]),
        .FunSel (FunSel),
        .HalfLd (HalfLd),
        .LH     (LH),
        .I      (I),
        .Q      (regs[gi]),
        .Wrap   (wrap[gi])
      );
    end
  endgenerate

  // Read mux by compare-and-select: an index with no matching register
  // (>= DEPTH) falls through to zero without indexing out of range.
  always_comb begin
    O1 = '0;
    O2 = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (O1Sel == SELW'(k)) O1 = regs[k];
      if (O2Sel == SELW'(k)) O2 = regs[k];
    end
  end

  assign ovf_d = |wrap;

  always_ff @(posedge Clock) begin
    if (Reset) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  assign Ovf = ovf_q;

endmodule : param_reg_file

// File: tb/tb_param_reg_file.sv
module tb_param_reg_file;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Main instance: WIDTH=8, DEPTH=4
  logic       Reset;
  logic [7:0] I;
  logic [1:0] O1Sel, O2Sel, FunSel;
  logic [3:0] RSel;
  logic       HalfLd, LH;
  logic [7:0] O1, O2;
  logic       Ovf;

  param_reg_file dut (
    .Clock(clk), .Reset(Reset), .I(I), .O1Sel(O1Sel), .O2Sel(O2Sel),
    .FunSel(FunSel), .RSel(RSel), .HalfLd(HalfLd), .LH(LH),
    .O1(O1), .O2(O2), .Ovf(Ovf)
  );

  // DEPTH=5 instance (3-bit selects, indices 5..7 unused)
  logic [7:0] b_I;
  logic [2:0] b_O1Sel, b_O2Sel;
  logic [4:0] b_RSel;
  logic [7:0] b_O1, b_O2;
  logic       b_Ovf;

  param_reg_file #(.WIDTH(8), .DEPTH(5)) dut_d5 (
    .Clock(clk), .Reset(Reset), .I(b_I), .O1Sel(b_O1Sel), .O2Sel(b_O2Sel),
    .FunSel(FunSel), .RSel(b_RSel), .HalfLd(HalfLd), .LH(LH),
    .O1(b_O1), .O2(b_O2), .Ovf(b_Ovf)
  );

  // WIDTH=16 instance
  logic [15:0] c_I;
  logic [1:0]  c_O1Sel, c_O2Sel;
  logic [3:0]  c_RSel;
  logic [15:0] c_O1, c_O2;
  logic        c_Ovf;

  param_reg_file #(.WIDTH(16), .DEPTH(4)) dut_w16 (
    .Clock(clk), .Reset(Reset), .I(c_I), .O1Sel(c_O1Sel), .O2Sel(c_O2Sel),
    .FunSel(FunSel), .RSel(c_RSel), .HalfLd(HalfLd), .LH(LH),
    .O1(c_O1), .O2(c_O2), .Ovf(c_Ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    $display("check %-14s got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Read register idx through both ports (O1Sel = O2Sel) and compare.
  task automatic rd(input string tag, input logic [1:0] idx, input logic [7:0] exp);
    O1Sel = idx;
    O2Sel = idx;
    #1;
    check({tag, ".O1"}, {24'b0, O1}, {24'b0, exp});
    check({tag, ".O2"}, {24'b0, O2}, {24'b0, exp});
  endtask

  task automatic op(input logic [1:0] f, input logic [3:0] rs, input logic [7:0] d,
                    input logic hl, input logic lh);
    FunSel = f; RSel = rs; I = d; HalfLd = hl; LH = lh;
    tick();
    RSel = 4'b0000; HalfLd = 1'b0; LH = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; I = '0; O1Sel = '0; O2Sel = '0; FunSel = 2'b11;
    RSel = 4'b1111; HalfLd = 1'b0; LH = 1'b0;
    b_I = '0; b_O1Sel = '0; b_O2Sel = '0; b_RSel = '1;
    c_I = '0; c_O1Sel = '0; c_O2Sel = '0; c_RSel = '1;
    tick();
    Reset = 1'b0; RSel = '0; b_RSel = '0; c_RSel = '0;

    // Reset state
    rd("rst_r0", 2'd0, 8'h00);
    rd("rst_r3", 2'd3, 8'h00);
    check("rst_ovf", {31'b0, Ovf}, 32'd0);

    // Load A5 into R0 and R2; not visible before the edge
    FunSel = 2'b01; RSel = 4'b0101; I = 8'hA5; O1Sel = 2'd0; #1;
    check("no_wthru", {24'b0, O1}, 32'h00);
    tick();
    RSel = 4'b0000;
    O1Sel = 2'd0; O2Sel = 2'd1; #1;
    check("ld_r0", {24'b0, O1}, 32'hA5);
    check("ld_r1", {24'b0, O2}, 32'h00);
    O2Sel = 2'd2; #1;
    check("ld_r2", {24'b0, O2}, 32'hA5);
    check("ld_ovf", {31'b0, Ovf}, 32'd0);

    // RSel=0 holds regardless of FunSel
    op(2'b00, 4'b0000, 8'h00, 1'b0, 1'b0);
    rd("hold_r0", 2'd0, 8'hA5);

    // Half-word loads
    op(2'b01, 4'b0001, 8'h3C, 1'b0, 1'b0);
    rd("full_ld", 2'd0, 8'h3C);
    op(2'b01, 4'b0001, 8'h07, 1'b1, 1'b1);
    rd("half_hi", 2'd0, 8'h7C);
    op(2'b01, 4'b0001, 8'h0F, 1'b1, 1'b0);
    rd("half_lo", 2'd0, 8'h7F);

    // Increment wrap on R1
    op(2'b01, 4'b0010, 8'hFF, 1'b0, 1'b0);
    op(2'b11, 4'b0010, 8'h00, 1'b0, 1'b0);
`ifdef PARAM_RF_SAT_EN
    rd("inc_wrap", 2'd1, 8'hFF);
`else
    rd("inc_wrap", 2'd1, 8'h00);
`endif
    check("inc_ovf", {31'b0, Ovf}, 32'd1);
    op(2'b11, 4'b0000, 8'h00, 1'b0, 1'b0);
    check("ovf_1cyc", {31'b0, Ovf}, 32'd0);

    // Decrement wrap on R2
    op(2'b00, 4'b0100, 8'h00, 1'b0, 1'b0);
    rd("clr_r2", 2'd2, 8'h00);
    check("clr_ovf", {31'b0, Ovf}, 32'd0);
    op(2'b10, 4'b0100, 8'h00, 1'b0, 1'b0);
`ifdef PARAM_RF_SAT_EN
    rd("dec_wrap", 2'd2, 8'h00);
`else
    rd("dec_wrap", 2'd2, 8'hFF);
`endif
    check("dec_ovf", {31'b0, Ovf}, 32'd1);

    // Plain inc/dec; HalfLd/LH ignored on increment
    op(2'b11, 4'b0001, 8'h00, 1'b1, 1'b1);
    rd("inc_r0", 2'd0, 8'h80);
    check("inc_noovf", {31'b0, Ovf}, 32'd0);
    op(2'b10, 4'b0001, 8'h00, 1'b0, 1'b0);
    rd("dec_r0", 2'd0, 8'h7F);

    // Increment all: one register at the boundary raises Ovf
    op(2'b11, 4'b1111, 8'h00, 1'b0, 1'b0);
    rd("all_r0", 2'd0, 8'h80);
    rd("all_r3", 2'd3, 8'h01);
`ifdef PARAM_RF_SAT_EN
    rd("all_r1", 2'd1, 8'hFF);
    rd("all_r2", 2'd2, 8'h01);
`else
    rd("all_r1", 2'd1, 8'h01);
    rd("all_r2", 2'd2, 8'h00);
`endif
    check("all_ovf", {31'b0, Ovf}, 32'd1);

    // Reset wins over a simultaneous increment
    Reset = 1'b1; FunSel = 2'b11; RSel = 4'b1111;
    tick();
    Reset = 1'b0; RSel = 4'b0000;
    rd("rr_r0", 2'd0, 8'h00);
    rd("rr_r1", 2'd1, 8'h00);
    rd("rr_r2", 2'd2, 8'h00);
    rd("rr_r3", 2'd3, 8'h00);
    check("rr_ovf", {31'b0, Ovf}, 32'd0);

    // DEPTH=5: out-of-range indices read zero
    FunSel = 2'b01; b_RSel = 5'b11111; b_I = 8'h5A;
    tick();
    b_RSel = '0;
    b_O1Sel = 3'd7; b_O2Sel = 3'd4; #1;
    check("d5_sel7", {24'b0, b_O1}, 32'h00);
    check("d5_sel4", {24'b0, b_O2}, 32'h5A);
    b_O1Sel = 3'd5; #1;
    check("d5_sel5", {24'b0, b_O1}, 32'h00);

    // WIDTH=16: full and high-half load
    FunSel = 2'b01; c_RSel = 4'b0001; c_I = 16'hBEEF;
    tick();
    c_O1Sel = 2'd0; #1;
    check("w16_ld", {16'b0, c_O1}, 32'hBEEF);
    HalfLd = 1'b1; LH = 1'b1; c_I = 16'h0012;
    tick();
    c_RSel = '0; HalfLd = 1'b0; LH = 1'b0; #1;
    check("w16_half", {16'b0, c_O1}, 32'h12EF);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule : tb_param_reg_file

// File: doc/param_reg_file.md
PARAM_REG_FILE -- requirements
Module: param_reg_file

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width of each register; even, >= 4.
REQ-002 SHALL have parameter DEPTH, default 4, number of registers; 2..16.
REQ-003 SHALL have parameter SELW, default $clog2(DEPTH), width of the read-select inputs.
REQ-004 SHALL have port Clock  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port I  input  WIDTH  write data.
REQ-007 SHALL have port O1Sel  input  SELW  read port 1 register index.
REQ-008 SHALL have port O2Sel  input  SELW  read port 2 register index.
REQ-009 SHALL have port FunSel  input  2  00 clear, 01 load, 10 decrement, 11 increment.
REQ-010 SHALL have port RSel  input  DEPTH  one-hot-or-multi enable mask, bit k = register k.
REQ-011 SHALL have port HalfLd  input  1  1 = load only one half-word.
REQ-012 SHALL have port LH  input  1  half select when HalfLd=1: 0 low half, 1 high half.
REQ-013 SHALL have port O1  output  WIDTH  contents of register O1Sel.
REQ-014 SHALL have port O2  output  WIDTH  contents of register O2Sel.
REQ-015 SHALL have port Ovf  output  1  registered wrap/saturation flag of the previous operation.

Function
REQ-016 SHALL update every register k with RSel[k]=1 on each rising Clock edge per FunSel; registers with RSel[k]=0 hold.
REQ-017 SHALL, with RSel all zero, hold all registers; FunSel, HalfLd and LH are ignored.
REQ-018 SHALL, on clear, write 0 to every enabled register.
REQ-019 SHALL, on load with HalfLd=0, write I to every enabled register.
REQ-020 SHALL, on load with HalfLd=1, write I[WIDTH/2-1:0] into the half chosen by LH and preserve the other half.
REQ-021 SHALL ignore HalfLd and LH for FunSel other than load.
REQ-022 SHALL, on increment/decrement, compute modulo 2^WIDTH: 0 decremented gives all-ones; all-ones incremented gives 0.
REQ-023 SHALL drive O1/O2 combinationally from the stored array; a write becomes visible one cycle after its edge (no write-through).
REQ-024 SHALL permit O1Sel = O2Sel; both ports then carry identical data.
REQ-025 SHALL drive O1/O2 to 0 when the select index is >= DEPTH.
REQ-026 SHALL set Ovf for exactly one cycle after an edge where any enabled register wrapped on increment or decrement, else clear it.
REQ-027 SHALL never set Ovf for clear or load.

Reset
REQ-028 SHALL, when Reset=1 at a rising edge, zero all registers and Ovf regardless of FunSel/RSel.
REQ-029 SHALL give Reset priority over any simultaneous operation; an operation issued in the reset cycle is discarded.
REQ-030 SHALL present O1=O2=0 and Ovf=0 in the cycle after reset.

Configuration
REQ-031 SHALL use macro PARAM_RF_SAT_EN to select saturating arithmetic.
REQ-032 SHALL, with PARAM_RF_SAT_EN defined, clamp increment at all-ones and decrement at 0, setting Ovf when a clamp occurs.
REQ-033 SHALL, without PARAM_RF_SAT_EN, use the modulo behaviour of REQ-022.

Structure
REQ-034 SHALL place the FunSel encoding typedef (RF_CLR, RF_LOAD, RF_DEC, RF_INC) in shared package param_rf_pkg.
REQ-035 SHALL implement one register plus its function logic and wrap detection as sub-module rf_cell, instantiated DEPTH times.
REQ-036 SHALL compute Ovf as the registered OR of the per-cell wrap outputs.

Verification
REQ-037 SHALL cover: reset, then load I=8'hA5 with RSel=4'b0101 -> next cycle O1Sel=0 gives A5, O2Sel=1 gives 00, O2Sel=2 gives A5.
REQ-038 SHALL cover: R0=8'h3C, HalfLd=1, LH=1, I=8'h07 -> R0=8'h7C; then LH=0, I=8'h0F -> R0=8'h7F.
REQ-039 SHALL cover: R1=8'hFF, increment -> R1=00, Ovf=1 for one cycle (PARAM_RF_SAT_EN defined: R1 stays FF, Ovf=1).
REQ-040 SHALL cover: R2=00, decrement -> R2=FF, Ovf=1 (PARAM_RF_SAT_EN defined: R2 stays 00, Ovf=1).
REQ-041 SHALL cover: increment with RSel=4'b1111 and Reset=1 in the same cycle -> all registers 00, Ovf=0.
REQ-042 SHALL cover: DEPTH=5, O1Sel=7 -> O1=0; WIDTH=16 instance load 16'hBEEF -> O1=BEEF.
